tx_arbiter_req_recorder: RTL and testbench
==========================================

# tx_arbiter_req_recorder

- Records transmit requests from the five Tx arbiter sources in arrival order and presents the two oldest to the Tx arbiter FSM as TLP1/TLP2 candidates.
- Sources: A2P_1 (write), A2P_2 (read), MASTER, RX_ROUTER_CFG, RX_ROUTER_ERR.
- Sits directly upstream of the arbiter. The FSM pops one or two entries per cycle after flow-control and ordering checks pass.
- Simultaneous requests are serialized one per cycle by fixed priority.

## Interface
- DATA_WIDTH, 3, width of one entry (Tx_Arbiter_Sources_t encoding)
- FIFO_DEPTH, 4, number of entries, power of two
- NUM_SRC, 5, number of request sources
- clk  in  1  clock, all state on rising edge
- arst_n  in  1  asynchronous active-low reset
- req  in  NUM_SRC  request pulses; bit0 A2P_1, bit1 A2P_2, bit2 MASTER, bit3 RX_ROUTER_CFG, bit4 RX_ROUTER_ERR
- pop_cnt  in  2  entries consumed this cycle: 0, 1 or 2; value 3 is treated as 0
- src_1  out  DATA_WIDTH  oldest entry; NO_SOURCE (0) when empty
- src_2  out  DATA_WIDTH  second-oldest entry; NO_SOURCE when count<2
- count  out  $clog2(FIFO_DEPTH+1)  occupied entries
- full  out  1  count==FIFO_DEPTH
- empty  out  1  count==0
- pending  out  NUM_SRC  requests latched but not yet enqueued
- req_drop  out  1  sticky flag: a request was merged into a still-pending request
- pop_err  out  1  sticky flag: pop_cnt exceeded count

## Operation
- **Pending register:** one bit per source.
  - req[i] sets pending[i] at the edge.
  - pending[i] clears at the edge where source i is enqueued.
  - If req[i] arrives on the same edge that source i is enqueued, pending[i] stays set and no drop is flagged.
  - If req[i] arrives while pending[i] is set and not being enqueued, the request is merged and req_drop sets.
- **Selection:**
  - Only the registered pending vector takes part; req is not bypassed.
  - Priority: RX_ROUTER_ERR > RX_ROUTER_CFG > MASTER > A2P_2 > A2P_1.
  - At most one enqueue per cycle.
- **Enqueue condition:** pending!=0 and (count - eff_pop) < FIFO_DEPTH.
  - A full FIFO accepts a write in the same cycle as a pop.
  - Written value is the source encoding, index i maps to code i+1.
- **Pop:** eff_pop = min(pop_cnt, count), with pop_cnt==3 treated as 0.
  - If pop_cnt (1 or 2) > count, pop_err sets and only count entries are removed.
- **Storage:**
  - Circular buffer with rd_ptr and wr_ptr, each $clog2(FIFO_DEPTH) bits, wrapping modulo FIFO_DEPTH.
  - rd_ptr += eff_pop.
  - wr_ptr += 1 on enqueue.
  - count_next = count - eff_pop + enq; it never exceeds FIFO_DEPTH and never goes below 0.
- **Outputs:**
  - src_1 = mem[rd_ptr] when count>=1.
  - src_2 = mem[rd_ptr+1 mod DEPTH] when count>=2.
  - Both are combinational from registered state; otherwise NO_SOURCE.
- **Duplicates:** the same source may occupy several entries.

## Timing
- **Reset values:**
  - Outputs: src_1=src_2=NO_SOURCE, count=0, empty=1, full=0, pending=0, req_drop=0, pop_err=0.
  - Internal state: pointers 0; memory contents don't-care.
- **Reset mid-operation:** all entries and pending requests are discarded immediately (asynchronous); nothing is replayed.
- **Latency:**
  - req sampled at edge E.
  - pending is visible after E.
  - Entry is written at E+1.
  - On an empty FIFO, src_1 is valid after E+1 (2 cycles from req assertion).
- **Burst:** k simultaneous requests on a non-full FIFO enqueue on k consecutive edges in priority order.
- **Pop timing:** pop_cnt is sampled at the edge; src_1/src_2 reflect the new head after that edge.
- **Pop with write:** pop of 2 with simultaneous enqueue at count 2 gives count 1, and the new entry is at src_1.
- **Full stall:** when full with no pop, pending bits are held indefinitely and no entry is overwritten.

## Test plan
- **Reset then single request:** pulse req=5'b00100 for one cycle.
  - pending=00100 after edge 1.
  - src_1=MASTER(3), count=1 after edge 2.
  - src_2=NO_SOURCE.
- **Simultaneous burst:** req=5'b11111 in one cycle, no pops.
  - Entries in order: ERR(5), CFG(4), MASTER(3), A2P_2(2).
  - FIFO is then full, pending=00001.
  - pop_cnt=1 causes A2P_1(1) to enqueue on the same edge; count stays 4.
- **Double pop with wrap:**
  - Fill 4 entries and pop 2: src_1/src_2 show entries 3/4.
  - Enqueue 2 more (wr_ptr wraps to 2) and pop 2: src_1/src_2 show entries 5/6 in order.
- **Merge and drop:**
  - With the FIFO full and pending[0] set, pulse req[0]: req_drop=1, pending unchanged.
  - req[1] pulsed on the edge A2P_2 is enqueued: pending[1] stays 1, no drop.
- **Over-pop and illegal pop:**
  - count=1 with pop_cnt=2: count=0, empty=1, pop_err=1.
  - pop_cnt=3 at count=2: count stays 2, pop_err unchanged.
- **Async reset mid-burst:**
  - Assert arst_n low between edges while count=3 and pending=01010.
  - All outputs go to reset values immediately, without waiting for a clock edge.
  - After release, no stale entry appears.

Source files
------------

// File: rtl/tx_arbiter_req_recorder.sv
// ----------------------------------------------------------------------------
// tx_arbiter_req_recorder
//
// Records transmit requests from the five Tx arbiter sources in arrival order
// and presents the two oldest to the Tx arbiter FSM as TLP1/TLP2 candidates.
// Requests are first latched into a per-source pending register; one pending
// source per cycle (fixed priority, highest index first) is written into a
// small circular FIFO. The FSM consumes 0, 1 or 2 entries per cycle.
//
// Ports
//   clk       in   clock, all state on rising edge
//   arst_n    in   asynchronous active-low reset
//   req       in   request pulses, bit i = source code i+1
//                  (A2P_1, A2P_2, MASTER, RX_ROUTER_CFG, RX_ROUTER_ERR)
//   pop_cnt   in   entries consumed this cycle (0..2, 3 behaves as 0)
//   src_1     out  oldest entry, NO_SOURCE (0) when empty
//   src_2     out  second-oldest entry, NO_SOURCE when fewer than two
//   count     out  occupied entries
//   full      out  count == FIFO_DEPTH
//   empty     out  count == 0
//   pending   out  requests latched but not yet enqueued
//   req_drop  out  sticky: a request merged into a still-pending one
//   pop_err   out  sticky: pop_cnt exceeded count
// ----------------------------------------------------------------------------
module tx_arbiter_req_recorder #(
    parameter  int DATA_WIDTH = 3,
    parameter  int FIFO_DEPTH = 4,   // power of two, at least 2
    parameter  int NUM_SRC    = 5,
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1),
    localparam int PTR_W      = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic [NUM_SRC-1:0]    req,
    input  logic [1:0]            pop_cnt,
    output logic [DATA_WIDTH-1:0] src_1,
    output logic [DATA_WIDTH-1:0] src_2,
    output logic [CNT_W-1:0]      count,
    output logic                  full,
    output logic                  empty,
    output logic [NUM_SRC-1:0]    pending,
    output logic                  req_drop,
    output logic                  pop_err
);

    localparam logic [DATA_WIDTH-1:0] NO_SOURCE = '0;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [NUM_SRC-1:0]    r_pending;
    logic                  r_req_drop;
    logic                  r_pop_err;

    logic [CNT_W-1:0]      w_pop_req;
    logic                  w_pop_over;
    logic [CNT_W-1:0]      w_eff_pop;
    logic [CNT_W-1:0]      w_cnt_after_pop;
    logic [NUM_SRC-1:0]    w_sel_onehot;
    logic [DATA_WIDTH-1:0] w_sel_code;
    logic                  w_enq;
    logic [NUM_SRC-1:0]    w_enq_mask;
    logic [PTR_W-1:0]      w_rd_ptr_p1;

    // Pop amount: 3 is an illegal encoding and consumes nothing; a request
    // larger than the occupancy is clipped to what is actually there.
    always_comb begin
        w_pop_req       = (pop_cnt == 2'd3) ? '0 : CNT_W'(pop_cnt);
        w_pop_over      = (w_pop_req > r_count);
        w_eff_pop       = w_pop_over ? r_count : w_pop_req;
        w_cnt_after_pop = r_count - w_eff_pop;
    end

    // Fixed-priority pick among registered pending bits; scanning upward lets
    // the highest index (RX_ROUTER_ERR) win.
    // NOTE: every always_comb output gets a default before any conditional
    // assignment, otherwise a latch is inferred.
    always_comb begin
        w_sel_onehot = '0;
        w_sel_code   = NO_SOURCE;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_pending[i]) begin
                w_sel_onehot    = '0;
                w_sel_onehot[i] = 1'b1;
                w_sel_code      = DATA_WIDTH'(i + 1);
            end
        end
    end

    // Space is judged after this cycle's pop, so a full FIFO that is being
    // popped still accepts a write.
    assign w_enq      = (|r_pending) && (w_cnt_after_pop < CNT_W'(FIFO_DEPTH));
    assign w_enq_mask = w_enq ? w_sel_onehot : '0;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_pending  <= '0;
            r_req_drop <= 1'b0;
            r_pop_err  <= 1'b0;
        end else begin
            // A new request on the edge its source is enqueued re-arms the bit.
            r_pending <= (r_pending & ~w_enq_mask) | req;
            if (|(req & r_pending & ~w_enq_mask)) begin
                r_req_drop <= 1'b1;
            end
            if (w_pop_over) begin
                r_pop_err <= 1'b1;
            end
            r_rd_ptr <= r_rd_ptr + PTR_W'(w_eff_pop);
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_count <= w_cnt_after_pop + CNT_W'(w_enq);
        end
    end

    // NOTE: the storage array has no reset; occupancy gates every read, so
    // stale contents are never visible and the array maps onto plain flops/RAM.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= w_sel_code;
        end
    end

    assign w_rd_ptr_p1 = r_rd_ptr + PTR_W'(1);

    assign src_1    = (r_count >= CNT_W'(1)) ? r_mem[r_rd_ptr]    : NO_SOURCE;
    assign src_2    = (r_count >= CNT_W'(2)) ? r_mem[w_rd_ptr_p1] : NO_SOURCE;
    assign count    = r_count;
    assign full     = (r_count == CNT_W'(FIFO_DEPTH));
    assign empty    = (r_count == '0);
    assign pending  = r_pending;
    assign req_drop = r_req_drop;
    assign pop_err  = r_pop_err;

endmodule

// File: tb/tb_tx_arbiter_req_recorder.sv
// ----------------------------------------------------------------------------
// tb_tx_arbiter_req_recorder
//
// Directed bench for tx_arbiter_req_recorder. Inputs change 1 ns after a
// rising edge and outputs are sampled at that same point, well clear of the
// active edge. Expected values are hand-derived from the request/pop history.
// ----------------------------------------------------------------------------
module tb_tx_arbiter_req_recorder;

    logic       clk;
    logic       arst_n;
    logic [4:0] req;
    logic [1:0] pop_cnt;
    logic [2:0] src_1;
    logic [2:0] src_2;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic [4:0] pending;
    logic       req_drop;
    logic       pop_err;

    int n_checks = 0;
    int n_pass   = 0;

    tx_arbiter_req_recorder dut (
        .clk      (clk),
        .arst_n   (arst_n),
        .req      (req),
        .pop_cnt  (pop_cnt),
        .src_1    (src_1),
        .src_2    (src_2),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .pending  (pending),
        .req_drop (req_drop),
        .pop_err  (pop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Apply inputs for one edge, then land 1 ns after it.
    task automatic step(input logic [4:0] r, input logic [1:0] p);
        req     = r;
        pop_cnt = p;
        @(posedge clk);
        #1;
        req     = '0;
        pop_cnt = '0;
    endtask

    task automatic check_fifo(input string tag, input logic [2:0] c,
                              input logic [2:0] s1, input logic [2:0] s2);
        check({tag, ".count"}, count, c);
        check({tag, ".src_1"}, src_1, s1);
        check({tag, ".src_2"}, src_2, s2);
        check({tag, ".empty"}, empty, c == 3'd0);
        check({tag, ".full"},  full,  c == 3'd4);
    endtask

    initial begin
        arst_n  = 1'b0;
        req     = '0;
        pop_cnt = '0;
        #12;
        // Reset state
        check_fifo("rst", 3'd0, 3'd0, 3'd0);
        check("rst.pending",  pending,  5'b00000);
        check("rst.req_drop", req_drop, 1'b0);
        check("rst.pop_err",  pop_err,  1'b0);
        @(posedge clk);
        #3;
        arst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single request: pending after first edge, entry after second
        step(5'b00100, 2'd0);
        check("single.pending1", pending, 5'b00100);
        check("single.count1",   count,   3'd0);
        step(5'b00000, 2'd0);
        check_fifo("single.e2", 3'd1, 3'd3, 3'd0);
        check("single.pending2", pending, 5'b00000);
        step(5'b00000, 2'd1);
        check_fifo("single.pop", 3'd0, 3'd0, 3'd0);

        // Request on the edge its own source is enqueued: no drop, duplicates
        step(5'b00010, 2'd0);
        check("renq.pending1", pending, 5'b00010);
        step(5'b00010, 2'd0);
        check("renq.pending2", pending, 5'b00010);
        check("renq.drop",     req_drop, 1'b0);
        check("renq.count",    count,    3'd1);
        step(5'b00000, 2'd0);
        check_fifo("renq.dup", 3'd2, 3'd2, 3'd2);
        step(5'b00000, 2'd2);
        check_fifo("renq.pop2", 3'd0, 3'd0, 3'd0);
        check("renq.pop_err", pop_err, 1'b0);

        // Simultaneous burst serialized by priority
        step(5'b11111, 2'd0);
        check("burst.pending", pending, 5'b11111);
        step(5'b00000, 2'd0);
        check_fifo("burst.e1", 3'd1, 3'd5, 3'd0);
        step(5'b00000, 2'd0);
        check_fifo("burst.e2", 3'd2, 3'd5, 3'd4);
        step(5'b00000, 2'd0);
        step(5'b00000, 2'd0);
        check_fifo("burst.full", 3'd4, 3'd5, 3'd4);
        check("burst.pending_left", pending, 5'b00001);
        step(5'b00000, 2'd0);
        check_fifo("stall", 3'd4, 3'd5, 3'd4);
        check("stall.pending", pending, 5'b00001);

        // Merge into still-pending request while full
        step(5'b00001, 2'd0);
        check("merge.drop",    req_drop, 1'b1);
        check("merge.pending", pending,  5'b00001);
        check("merge.count",   count,    3'd4);

        // Pop from full with simultaneous write of A2P_1
        step(5'b00000, 2'd1);
        check_fifo("popwr", 3'd4, 3'd4, 3'd3);
        check("popwr.pending", pending, 5'b00000);

        // Double pop, then refill across the pointer wrap
        step(5'b00000, 2'd2);
        check_fifo("dpop1", 3'd2, 3'd2, 3'd1);
        step(5'b00101, 2'd0);
        step(5'b00000, 2'd0);
        step(5'b00000, 2'd0);
        check_fifo("refill", 3'd4, 3'd2, 3'd1);
        step(5'b00000, 2'd2);
        check_fifo("dpop2", 3'd2, 3'd3, 3'd1);

        // Illegal pop encoding consumes nothing and is not an error
        step(5'b00000, 2'd3);
        check_fifo("pop3", 3'd2, 3'd3, 3'd1);
        check("pop3.pop_err", pop_err, 1'b0);

        // Pop 2 with enqueue at count 2: new entry becomes head
        step(5'b10000, 2'd0);
        check("p2w.pending", pending, 5'b10000);
        step(5'b00000, 2'd2);
        check_fifo("p2w", 3'd1, 3'd5, 3'd0);

        // Over-pop
        step(5'b00000, 2'd2);
        check_fifo("overpop", 3'd0, 3'd0, 3'd0);
        check("overpop.pop_err", pop_err, 1'b1);

        // Build count=3, pending=01010, then async reset between edges
        step(5'b00111, 2'd0);
        step(5'b00000, 2'd0);
        step(5'b00000, 2'd0);
        step(5'b01010, 2'd0);
        check_fifo("pre_rst", 3'd3, 3'd3, 3'd2);
        check("pre_rst.pending", pending, 5'b01010);
        arst_n = 1'b0;
        #1;
        check_fifo("arst", 3'd0, 3'd0, 3'd0);
        check("arst.pending",  pending,  5'b00000);
        check("arst.req_drop", req_drop, 1'b0);
        check("arst.pop_err",  pop_err,  1'b0);
        #1;
        arst_n = 1'b1;
        step(5'b00000, 2'd0);
        step(5'b00000, 2'd0);
        check_fifo("post_rst", 3'd0, 3'd0, 3'd0);
        check("post_rst.pending", pending, 5'b00000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
